// File: rtl/isdu_pkg.sv
// Shared types and encodings for the LC-3 instruction sequence/decode unit.
// The mux encodings are also used by the datapath mux decoders.
package isdu_pkg;

  typedef enum logic [4:0] {
    S_HALTED,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    S_BR_TAKEN,
    S_JMP,
    S_JSR1,
    S_JSR2,
    S_LDR1,
    S_LDR2,
    S_LDR3,
    S_STR1,
    S_STR2,
    S_STR3,
    S_PAUSE1,
    S_PAUSE2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_ADDER = 2'b01;
  localparam logic [1:0] PCMUX_BUS   = 2'b10;

  localparam logic [1:0] ADDR2_ZERO   = 2'b00;
  localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
  localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
  localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       drmux;
    logic       sr1mux;
    logic       sr2mux;
    logic [1:0] aluk;
    logic       mio_en;
    logic       mem_oe;
    logic       mem_we;
  } ctrl_t;

  // States that hold an SRAM strobe for MEM_WAIT cycles.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
  endfunction

endpackage

// File: rtl/isdu_mem_wait_timer.sv
// Down-counter that times one SRAM access: loaded with MEM_WAIT on entry to a
// memory state, done while the count reads 1.
module isdu_mem_wait_timer #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = $clog2(MEM_WAIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(MEM_WAIT);
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == CW'(1));

endmodule

// File: rtl/isdu.sv
// LC-3 instruction sequence/decode unit: Moore FSM driving the datapath loads,
// bus gates, mux selects and active-low SRAM strobes.
module isdu
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [4:0] state_dbg
);

  state_t state;
  state_t next_state;
  ctrl_t  c;
  logic   wait_done;
  logic   wait_load;
  logic   wait_dec;

  // Reload only on entry so a held access counts down undisturbed.
  assign wait_load = is_mem_state(next_state) && (next_state != state);
  assign wait_dec  = is_mem_state(state);

  isdu_mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .clk   (clk),
    .reset (Reset),
    .load  (wait_load),
    .dec   (wait_dec),
    .done  (wait_done)
  );

  always_ff @(posedge clk) begin
    if (Reset) state <= S_HALTED;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_HALTED:   if (Run) next_state = S_FETCH1;
      S_FETCH1:   next_state = S_FETCH2;
      S_FETCH2:   if (wait_done) next_state = S_FETCH3;
      S_FETCH3:   next_state = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_ADD:   next_state = S_ADD;
          OP_AND:   next_state = S_AND;
          OP_NOT:   next_state = S_NOT;
          OP_BR:    next_state = BEN ? S_BR_TAKEN : S_FETCH1;
          OP_JMP:   next_state = S_JMP;
          OP_JSR:   next_state = IR_11 ? S_JSR1 : S_FETCH1;
          OP_LDR:   next_state = S_LDR1;
          OP_STR:   next_state = S_STR1;
          OP_PAUSE: next_state = S_PAUSE1;
          default:  next_state = S_FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP, S_JSR2, S_LDR3:
                  next_state = S_FETCH1;
      S_JSR1:     next_state = S_JSR2;
      S_LDR1:     next_state = S_LDR2;
      S_LDR2:     if (wait_done) next_state = S_LDR3;
      S_STR1:     next_state = S_STR2;
      S_STR2:     next_state = S_STR3;
      S_STR3:     if (wait_done) next_state = S_FETCH1;
      // Continue is a level: a full high-then-low pulse releases the pause.
      S_PAUSE1:   if (Continue) next_state = S_PAUSE2;
      S_PAUSE2:   if (!Continue) next_state = S_FETCH1;
      default:    next_state = S_HALTED;
    endcase
  end

  always_comb begin
    c        = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    case (state)
      S_FETCH1: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.pcmux   = PCMUX_INC;
        c.ld_pc   = 1'b1;
      end
      S_FETCH2, S_LDR2: begin
        c.mem_oe = 1'b0;
        c.mio_en = 1'b1;
        c.ld_mdr = wait_done;
      end
      S_FETCH3: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      S_DECODE: c.ld_ben = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        c.sr1mux   = 1'b1;
        c.aluk     = (state == S_ADD) ? ALUK_ADD :
                     (state == S_AND) ? ALUK_AND : ALUK_NOT;
        c.sr2mux   = (state != S_NOT) ? IR_5 : 1'b0;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S_BR_TAKEN: begin
        c.addr1mux = 1'b1;
        c.addr2mux = ADDR2_SEXT9;
        c.pcmux    = PCMUX_ADDER;
        c.ld_pc    = 1'b1;
      end
      S_JMP: begin
        c.sr1mux   = 1'b1;
        c.aluk     = ALUK_PASSA;
        c.gate_alu = 1'b1;
        c.pcmux    = PCMUX_BUS;
        c.ld_pc    = 1'b1;
      end
      S_JSR1: begin
        c.gate_pc = 1'b1;
        c.drmux   = 1'b1;
        c.ld_reg  = 1'b1;
      end
      S_JSR2: begin
        c.addr1mux = 1'b1;
        c.addr2mux = ADDR2_SEXT11;
        c.pcmux    = PCMUX_ADDER;
        c.ld_pc    = 1'b1;
      end
      S_LDR1, S_STR1: begin
        c.sr1mux      = 1'b1;
        c.addr2mux    = ADDR2_SEXT6;
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
      end
      S_LDR3: begin
        c.gate_mdr = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      // Store data comes from SR (IR[11:9]) through the ALU pass-A path.
      S_STR2: begin
        c.aluk     = ALUK_PASSA;
        c.gate_alu = 1'b1;
        c.ld_mdr   = 1'b1;
      end
      S_STR3:   c.mem_we = 1'b0;
      S_PAUSE1: c.ld_led = 1'b1;
      default: ;
    endcase
  end

  assign LD_MAR     = c.ld_mar;
  assign LD_MDR     = c.ld_mdr;
  assign LD_IR      = c.ld_ir;
  assign LD_BEN     = c.ld_ben;
  assign LD_CC      = c.ld_cc;
  assign LD_REG     = c.ld_reg;
  assign LD_PC      = c.ld_pc;
  assign LD_LED     = c.ld_led;
  assign GatePC     = c.gate_pc;
  assign GateMDR    = c.gate_mdr;
  assign GateALU    = c.gate_alu;
  assign GateMARMUX = c.gate_marmux;
  assign PCMUX      = c.pcmux;
  assign ADDR1MUX   = c.addr1mux;
  assign ADDR2MUX   = c.addr2mux;
  assign DRMUX      = c.drmux;
  assign SR1MUX     = c.sr1mux;
  assign SR2MUX     = c.sr2mux;
  assign ALUK       = c.aluk;
  assign MIO_EN     = c.mio_en;
  assign Mem_OE     = c.mem_oe;
  assign Mem_WE     = c.mem_we;
  assign state_dbg  = state;

endmodule

// File: tb/tb_isdu.sv
// Bench for isdu: two instances (MEM_WAIT 2 and 3), per-cycle expected control
// words built from the instruction's micro-step list, plus cycle-count vectors.
module tb_isdu;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       drmux;
    logic       sr1mux;
    logic       sr2mux;
    logic [1:0] aluk;
    logic       mio_en;
    logic       mem_oe;
    logic       mem_we;
  } ctrl_t;

  localparam int CW = $bits(ctrl_t);

  typedef enum {
    K_HALT, K_F1, K_RD, K_RDL, K_F3, K_DEC, K_ADD, K_AND, K_NOT, K_BRT,
    K_JMP, K_JSR1, K_JSR2, K_ADDR, K_LDR3, K_STR2, K_WR, K_P1, K_P2
  } kind_e;

  typedef struct {
    logic [3:0] op;
    logic       ir5;
    logic       ir11;
    logic       ben;
    int         wmul;
    int         add;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_r  [2];
  logic       run_r  [2];
  logic       cont_r [2];
  logic       ir5_r  [2];
  logic       ir11_r [2];
  logic       ben_r  [2];
  logic [3:0] op_r   [2];
  ctrl_t      act    [2];
  logic [4:0] dbg    [2];

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic [CW:0] exp_q[$];
  vec_t tbl [12];

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic addr1mux, drmux, sr1mux, sr2mux, mio_en, mem_oe, mem_we;
    logic [1:0] pcmux, addr2mux, aluk;
    logic [4:0] state_dbg;

    isdu #(.MEM_WAIT(g + 2)) u_dut (
      .clk(clk), .Reset(rst_r[g]), .Run(run_r[g]), .Continue(cont_r[g]),
      .Opcode(op_r[g]), .IR_5(ir5_r[g]), .IR_11(ir11_r[g]), .BEN(ben_r[g]),
      .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
      .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
      .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu),
      .GateMARMUX(gate_marmux), .PCMUX(pcmux), .ADDR1MUX(addr1mux),
      .ADDR2MUX(addr2mux), .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux),
      .ALUK(aluk), .MIO_EN(mio_en), .Mem_OE(mem_oe), .Mem_WE(mem_we),
      .state_dbg(state_dbg)
    );

    assign act[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                     gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, addr1mux,
                     addr2mux, drmux, sr1mux, sr2mux, aluk, mio_en, mem_oe, mem_we};
    assign dbg[g] = state_dbg;
  end

  // ---------------- reference: control word of each micro-step ----------------
  function automatic ctrl_t ctl(kind_e k, logic ir5);
    ctrl_t c;
    c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    case (k)
      K_F1:   begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
      K_RD:   begin c.mem_oe = 0; c.mio_en = 1; end
      K_RDL:  begin c.mem_oe = 0; c.mio_en = 1; c.ld_mdr = 1; end
      K_F3:   begin c.gate_mdr = 1; c.ld_ir = 1; end
      K_DEC:  c.ld_ben = 1;
      K_ADD:  begin c.sr1mux = 1; c.aluk = 2'b00; c.sr2mux = ir5;
                    c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      K_AND:  begin c.sr1mux = 1; c.aluk = 2'b01; c.sr2mux = ir5;
                    c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      K_NOT:  begin c.sr1mux = 1; c.aluk = 2'b10;
                    c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      K_BRT:  begin c.addr1mux = 1; c.addr2mux = 2'b10; c.pcmux = 2'b01; c.ld_pc = 1; end
      K_JMP:  begin c.sr1mux = 1; c.aluk = 2'b11; c.gate_alu = 1;
                    c.pcmux = 2'b10; c.ld_pc = 1; end
      K_JSR1: begin c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; end
      K_JSR2: begin c.addr1mux = 1; c.addr2mux = 2'b11; c.pcmux = 2'b01; c.ld_pc = 1; end
      K_ADDR: begin c.sr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1; end
      K_LDR3: begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      K_STR2: begin c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; end
      K_WR:   c.mem_we = 0;
      K_P1:   c.ld_led = 1;
      default: ;
    endcase
    return c;
  endfunction

  // Queue element: MSB is the Continue level to drive after that cycle is checked.
  task automatic push(kind_e k, logic ir5, logic cont);
    exp_q.push_back({cont, ctl(k, ir5)});
  endtask

  task automatic push_access(int w, kind_e last);
    for (int i = 1; i <= w; i++) push((i == w) ? last : ((last == K_WR) ? K_WR : K_RD), 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string nm, int k, ctrl_t want);
    n_cmp++;
    if (act[k] !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h (t=%0t)", nm, k, act[k], want, $time);
    end
  endtask

  task automatic check_int(string nm, int k, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d want %0d", nm, k, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int gates;
        gates = int'(act[k].gate_pc) + int'(act[k].gate_mdr) +
                int'(act[k].gate_alu) + int'(act[k].gate_marmux);
        n_cmp++;
        if (gates > 1 || (!act[k].mem_oe && !act[k].mem_we) || $isunknown(dbg[k])) begin
          n_bad++;
          $display("FAIL invariant dut%0d: gates=%0d oe=%b we=%b state=%b",
                   k, gates, act[k].mem_oe, act[k].mem_we, dbg[k]);
        end
      end
    end
  end

  task automatic drain(int k, string nm);
    logic [CW:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      check(nm, k, ctrl_t'(e[CW-1:0]));
      cont_r[k] = e[CW];
    end
  endtask

  // ---------------- driver tasks ----------------
  // Every task below starts and ends at the negedge of a FETCH1 cycle.
  task automatic exec(int k, logic [3:0] op, logic ir5, logic ir11, logic ben,
                      int p1, int p2, logic pre, string nm);
    int  w;
    int  n1;
    logic pre_eff;
    w        = k + 2;
    pre_eff  = pre && (op == 4'b1101);
    op_r[k]  = op;
    ir5_r[k] = ir5;
    ir11_r[k] = ir11;
    ben_r[k] = ben;
    cont_r[k] = 1'b0;
    run_r[k] = 1'($urandom_range(0, 1));
    push_access(w, K_RDL);
    push(K_F3, ir5, 1'b0);
    push(K_DEC, ir5, pre_eff);
    case (op)
      4'b0001: push(K_ADD, ir5, 1'b0);
      4'b0101: push(K_AND, ir5, 1'b0);
      4'b1001: push(K_NOT, ir5, 1'b0);
      4'b0000: if (ben) push(K_BRT, ir5, 1'b0);
      4'b1100: push(K_JMP, ir5, 1'b0);
      4'b0100: if (ir11) begin push(K_JSR1, ir5, 1'b0); push(K_JSR2, ir5, 1'b0); end
      4'b0110: begin push(K_ADDR, ir5, 1'b0); push_access(w, K_RDL); push(K_LDR3, ir5, 1'b0); end
      4'b0111: begin push(K_ADDR, ir5, 1'b0); push(K_STR2, ir5, 1'b0); push_access(w, K_WR); end
      4'b1101: begin
        n1 = pre_eff ? 1 : p1;
        for (int i = 0; i < n1; i++) push(K_P1, ir5, pre_eff || (i == n1 - 1));
        for (int j = 0; j < p2; j++) push(K_P2, ir5, j != p2 - 1);
      end
      default: ;
    endcase
    push(K_F1, ir5, 1'b0);
    drain(k, nm);
  endtask

  task automatic measure(int k, vec_t v);
    int n;
    op_r[k]   = v.op;
    ir5_r[k]  = v.ir5;
    ir11_r[k] = v.ir11;
    ben_r[k]  = v.ben;
    cont_r[k] = 1'b0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (act[k].gate_pc && act[k].ld_mar && act[k].ld_pc) break;
      n++;
    end
    check_int($sformatf("cycles_op%b_b%0d_j%0d", v.op, v.ben, v.ir11), k, n,
              v.wmul * (k + 2) + v.add);
  endtask

  task automatic start(int k);
    rst_r[k]  = 1'b1;
    run_r[k]  = 1'b1;
    cont_r[k] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_default", k, ctl(K_HALT, 1'b0));
    end
    rst_r[k]  = 1'b0;
    run_r[k]  = 1'b0;
    cont_r[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("halted_idle", k, ctl(K_HALT, 1'b0));
    run_r[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("run_fetch1", k, ctl(K_F1, 1'b0));
  endtask

  task automatic reset_mid_ldr(int k);
    op_r[k] = 4'b0110;
    push_access(k + 2, K_RDL);
    push(K_F3, 1'b0, 1'b0);
    push(K_DEC, 1'b0, 1'b0);
    push(K_ADDR, 1'b0, 1'b0);
    push(K_RD, 1'b0, 1'b0);
    drain(k, "ldr_pre_reset");
    rst_r[k]  = 1'b1;
    run_r[k]  = 1'b1;
    cont_r[k] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_mid_ldr2", k, ctl(K_HALT, 1'b0));
    end
    rst_r[k]  = 1'b0;
    run_r[k]  = 1'b0;
    cont_r[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("halted_after_reset", k, ctl(K_HALT, 1'b0));
    run_r[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart_fetch1", k, ctl(K_F1, 1'b0));
  endtask

  task automatic random_run(int k, int n);
    for (int i = 0; i < n; i++) begin
      exec(k, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(1, 3), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
           "random");
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_r[k] = 1'b1; run_r[k] = 1'b0; cont_r[k] = 1'b0;
      ir5_r[k] = 1'b0; ir11_r[k] = 1'b0; ben_r[k] = 1'b0; op_r[k] = 4'b0000;
    end
    // {opcode, IR_5, IR_11, BEN, cycles = wmul*W + add}
    tbl = '{'{4'b0001, 1'b1, 1'b0, 1'b0, 1, 4}, '{4'b0101, 1'b0, 1'b0, 1'b0, 1, 4},
            '{4'b1001, 1'b0, 1'b0, 1'b0, 1, 4}, '{4'b0000, 1'b0, 1'b0, 1'b0, 1, 3},
            '{4'b0000, 1'b0, 1'b0, 1'b1, 1, 4}, '{4'b1100, 1'b0, 1'b0, 1'b0, 1, 4},
            '{4'b0100, 1'b0, 1'b1, 1'b0, 1, 5}, '{4'b0100, 1'b0, 1'b0, 1'b0, 1, 3},
            '{4'b0110, 1'b0, 1'b0, 1'b0, 2, 5}, '{4'b0111, 1'b0, 1'b0, 1'b0, 2, 5},
            '{4'b1010, 1'b0, 1'b0, 1'b0, 1, 3}, '{4'b1111, 1'b1, 1'b1, 1'b1, 1, 3}};
    @(posedge clk);
    #1 chk_en = 1'b1;

    start(0);
    exec(0, 4'b0001, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, "add_w2");
    exec(0, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, "br_not_taken");
    exec(0, 4'b0000, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0, "br_taken");
    exec(0, 4'b0101, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, "and_reg");
    exec(0, 4'b1001, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, "not");
    exec(0, 4'b1100, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, "jmp");
    exec(0, 4'b0100, 1'b0, 1'b1, 1'b0, 1, 1, 1'b0, "jsr");
    exec(0, 4'b1101, 1'b0, 1'b0, 1'b0, 3, 3, 1'b0, "pause");
    exec(0, 4'b1101, 1'b0, 1'b0, 1'b0, 1, 2, 1'b1, "pause_cont_high");
    foreach (tbl[i]) measure(0, tbl[i]);
    random_run(0, 40);

    rst_r[0] = 1'b1;
    start(1);
    exec(1, 4'b0111, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, "str_w3");
    exec(1, 4'b0110, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, "ldr_w3");
    foreach (tbl[i]) measure(1, tbl[i]);
    random_run(1, 30);
    reset_mid_ldr(1);
    exec(1, 4'b0001, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, "add_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
